// File: rtl/delta_sigma_decimator_if.sv
// Sample-stream bundle for delta_sigma_decimator.
// master: the decimator side. It takes in the bitstream and drives out samples.
// slave : the environment side. It feeds bits and consumes samples.
interface delta_sigma_decimator_if #(
    parameter int DATA_SIZE = 16
) ();
    logic                 dataIn;
    logic                 dataInValid;
    logic [DATA_SIZE-1:0] dataOut;
    logic                 dataOutValid;
    logic                 dataOutReady;
    logic                 overrun;

    modport master (
        input  dataIn,
        input  dataInValid,
        input  dataOutReady,
        output dataOut,
        output dataOutValid,
        output overrun
    );

    modport slave (
        output dataIn,
        output dataInValid,
        output dataOutReady,
        input  dataOut,
        input  dataOutValid,
        input  overrun
    );
endinterface

// File: rtl/delta_sigma_decimator.sv
// delta_sigma_decimator: this block converts a 1-bit delta-sigma bitstream into PCM samples.
// It uses a third-order CIC (sinc3) filter with decimation ratio 2**LOG2_DECIM.
// After the filter come saturation, scaling and a one-entry valid/ready output register.
// Optional macro DELTA_SIGMA_DECIM_SIGNED_EN: when defined, dataOut is two's complement.
// The macro inverts the MSB of the scaled value. It does not change timing.
module delta_sigma_decimator #(
    parameter int DATA_SIZE  = 16,
    parameter int LOG2_DECIM = 6
) (
    input logic clk,
    input logic reset,
    delta_sigma_decimator_if.master bus
);
    localparam int GAIN_BITS = 3 * LOG2_DECIM;
    localparam int W         = GAIN_BITS + 1;

    typedef enum logic [1:0] {
        Settle0,
        Settle1,
        Running
    } settleState_t;

    logic [W-1:0]          integ1, integ2, integ3;
    logic [W-1:0]          integ1Next, integ2Next, integ3Next;
    logic [LOG2_DECIM-1:0] decimCnt;
    logic                  decimEvent;

    logic [W-1:0] capture, captureDly;
    logic [W-1:0] comb1, comb1Dly;
    logic [W-1:0] comb2, comb2Dly;
    logic [W-1:0] comb3;
    logic         capValid, comb1Valid, comb2Valid, comb3Valid;

    settleState_t         settle;
    logic                 load;
    logic [DATA_SIZE-1:0] scaled;
    logic [DATA_SIZE-1:0] outSample;
    logic                 combUnused;

    logic [DATA_SIZE-1:0] dataOutReg;
    logic                 dataOutValidReg;
    logic                 overrunReg;

    // Next integrator values. Each stage adds the previous registered value of the stage before it.
    always_comb begin
        integ1Next = integ1 + {{(W - 1){1'b0}}, bus.dataIn};
        integ2Next = integ2 + integ1;
        integ3Next = integ3 + integ2;
        decimEvent = bus.dataInValid && (decimCnt == '1);
    end

    // Integrators and the decimation counter advance only on accepted bits. They wrap modulo 2**W.
    always_ff @(posedge clk) begin
        if (reset) begin
            integ1   <= '0;
            integ2   <= '0;
            integ3   <= '0;
            decimCnt <= '0;
        end else if (bus.dataInValid) begin
            integ1   <= integ1Next;
            integ2   <= integ2Next;
            integ3   <= integ3Next;
            decimCnt <= decimCnt + 1'b1;
        end
    end

    // Capture register plus three comb stages. Each stage fires one cycle after the stage before it.
    // Each stage keeps x_prev from its own previous firing.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture    <= '0;
            captureDly <= '0;
            comb1      <= '0;
            comb1Dly   <= '0;
            comb2      <= '0;
            comb2Dly   <= '0;
            comb3      <= '0;
            capValid   <= 1'b0;
            comb1Valid <= 1'b0;
            comb2Valid <= 1'b0;
            comb3Valid <= 1'b0;
        end else begin
            capValid   <= decimEvent;
            comb1Valid <= capValid;
            comb2Valid <= comb1Valid;
            comb3Valid <= comb2Valid;
            if (decimEvent) begin
                capture <= integ3Next;
            end
            if (capValid) begin
                comb1      <= capture - captureDly;
                captureDly <= capture;
            end
            if (comb1Valid) begin
                comb2    <= comb1 - comb1Dly;
                comb1Dly <= comb1;
            end
            if (comb2Valid) begin
                comb3    <= comb2 - comb2Dly;
                comb2Dly <= comb2;
            end
        end
    end

    // Saturate R^3 to R^3-1, keep the top DATA_SIZE bits, then optionally convert to two's complement.
    // After settling the raw value is at most R^3, so its MSB is set only at exactly R^3.
    always_comb begin
        scaled = '0;
        if (comb3[GAIN_BITS]) begin
            scaled = '1;
        end else begin
            scaled = comb3[GAIN_BITS-1 -: DATA_SIZE];
        end
`ifdef DELTA_SIGMA_DECIM_SIGNED_EN
        outSample = {~scaled[DATA_SIZE-1], scaled[DATA_SIZE-2:0]};
`else
        outSample = scaled;
`endif
    end

    assign combUnused = ^comb3;
    assign load       = comb3Valid && (settle == Running);

    // Discard the first two comb results after reset. Until then the comb history is incomplete.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle <= Settle0;
        end else if (comb3Valid) begin
            case (settle)
                Settle0: settle <= Settle1;
                Settle1: settle <= Running;
                default: settle <= Running;
            endcase
        end
    end

    // Output register. A new sample always loads, and it overwrites an unconsumed one.
    // overrun flags only the overwrite case. A load together with an accepting handshake is a clean hand-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOutReg      <= '0;
            dataOutValidReg <= 1'b0;
            overrunReg      <= 1'b0;
        end else begin
            overrunReg <= load && dataOutValidReg && !bus.dataOutReady;
            if (load) begin
                dataOutReg      <= outSample;
                dataOutValidReg <= 1'b1;
            end else if (dataOutValidReg && bus.dataOutReady) begin
                dataOutValidReg <= 1'b0;
            end
        end
    end

    assign bus.dataOut      = dataOutReg;
    assign bus.dataOutValid = dataOutValidReg;
    assign bus.overrun      = overrunReg;
endmodule

// File: tb/tb_delta_sigma_decimator.sv
// Directed testbench for delta_sigma_decimator with DATA_SIZE=16 and LOG2_DECIM=6 (R=64).
// Expected samples are hand-computed third differences of the integrator sequence.
// Examples: C(n,3) for constant ones, and C(n,3)-C(n-192,3) for 192 ones followed by zeros.
module tb_delta_sigma_decimator;
    localparam int DATA_SIZE = 16;

    logic clk;
    logic reset;
    int   nChecks;
    int   nFails;

    delta_sigma_decimator_if #(.DATA_SIZE(DATA_SIZE)) bus ();

    delta_sigma_decimator #(
        .DATA_SIZE (DATA_SIZE),
        .LOG2_DECIM(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] expVal(input logic [15:0] u);
`ifdef DELTA_SIGMA_DECIM_SIGNED_EN
        return u ^ 16'h8000;
`else
        return u;
`endif
    endfunction

    task automatic step(input logic din, input logic dv);
        bus.dataIn      = din;
        bus.dataInValid = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset            = 1'b1;
        bus.dataIn       = 1'b0;
        bus.dataInValid  = 1'b0;
        bus.dataOutReady = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++;
        if (bus.dataOutValid !== 1'b0) begin
            nFails++;
            $display("FAIL reset_valid: got %b want 0", bus.dataOutValid);
        end
        nChecks++;
        if (bus.dataOut !== 16'h0000) begin
            nFails++;
            $display("FAIL reset_data: got %h want 0000", bus.dataOut);
        end
        nChecks++;
        if (bus.overrun !== 1'b0) begin
            nFails++;
            $display("FAIL reset_overrun: got %b want 0", bus.overrun);
        end
    endtask

    // Loads are expected at cycles 195, 259, 323 and 387.
    task automatic test_const_ones();
        int firstLoad = -1;
        int lastLoad = -1;
        int pulses = 0;
        doReset();
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'b1);
            if (i == 194) begin
                nChecks++;
                if (bus.dataOutValid !== 1'b0) begin
                    nFails++;
                    $display("FAIL ones_early_valid: got %b want 0 at cycle 194", bus.dataOutValid);
                end
            end
            if (bus.dataOutValid === 1'b1) begin
                pulses++;
                if (firstLoad < 0) firstLoad = i;
                nChecks++;
                if (bus.dataOut !== expVal(16'hFFFF)) begin
                    nFails++;
                    $display("FAIL ones_data: got %h want %h at cycle %0d", bus.dataOut, expVal(16'hFFFF), i);
                end
                if (lastLoad >= 0) begin
                    nChecks++;
                    if (i - lastLoad != 64) begin
                        nFails++;
                        $display("FAIL ones_spacing: got %0d want 64", i - lastLoad);
                    end
                end
                lastLoad = i;
            end
        end
        nChecks++;
        if (firstLoad != 195) begin
            nFails++;
            $display("FAIL ones_latency: got %0d want 195", firstLoad);
        end
        nChecks++;
        if (pulses != 4) begin
            nFails++;
            $display("FAIL ones_count: got %0d want 4", pulses);
        end
    endtask

    task automatic test_const_zeros();
        int pulses = 0;
        doReset();
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'b1);
            if (bus.dataOutValid === 1'b1) begin
                pulses++;
                nChecks++;
                if (bus.dataOut !== expVal(16'h0000)) begin
                    nFails++;
                    $display("FAIL zeros_data: got %h want %h at cycle %0d", bus.dataOut, expVal(16'h0000), i);
                end
            end
        end
        nChecks++;
        if (pulses != 4) begin
            nFails++;
            $display("FAIL zeros_count: got %0d want 4", pulses);
        end
    endtask

    task automatic test_alternating();
        int pulses = 0;
        doReset();
        for (int i = 0; i < 400; i++) begin
            step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
            if (bus.dataOutValid === 1'b1) begin
                pulses++;
                nChecks++;
                if (bus.dataOut !== expVal(16'h8000)) begin
                    nFails++;
                    $display("FAIL alt_data: got %h want %h at cycle %0d", bus.dataOut, expVal(16'h8000), i);
                end
            end
        end
        nChecks++;
        if (pulses != 4) begin
            nFails++;
            $display("FAIL alt_count: got %0d want 4", pulses);
        end
    endtask

    // Input is valid on even cycles only. The third event is at cycle 382, so loads occur at 386, 514 and 642.
    task automatic test_half_valid();
        int firstLoad = -1;
        int lastLoad = -1;
        int pulses = 0;
        doReset();
        for (int i = 0; i < 700; i++) begin
            step(1'b1, ((i % 2) == 0) ? 1'b1 : 1'b0);
            if (bus.dataOutValid === 1'b1) begin
                pulses++;
                if (firstLoad < 0) firstLoad = i;
                nChecks++;
                if (bus.dataOut !== expVal(16'hFFFF)) begin
                    nFails++;
                    $display("FAIL half_data: got %h want %h at cycle %0d", bus.dataOut, expVal(16'hFFFF), i);
                end
                if (lastLoad >= 0) begin
                    nChecks++;
                    if (i - lastLoad != 128) begin
                        nFails++;
                        $display("FAIL half_spacing: got %0d want 128", i - lastLoad);
                    end
                end
                lastLoad = i;
            end
        end
        nChecks++;
        if (firstLoad != 386) begin
            nFails++;
            $display("FAIL half_latency: got %0d want 386", firstLoad);
        end
        nChecks++;
        if (pulses != 3) begin
            nFails++;
            $display("FAIL half_count: got %0d want 3", pulses);
        end
    endtask

    // The input is 192 ones followed by zeros, with ready low until cycle 262.
    // Expected loads: 195 -> FFFF, 259 -> D750 (overwrite), 323 -> 2CB0, 387 -> 0000.
    task automatic test_overrun();
        int ovPulses = 0;
        doReset();
        bus.dataOutReady = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.dataOutReady = (i >= 262) ? 1'b1 : 1'b0;
            step((i < 192) ? 1'b1 : 1'b0, 1'b1);
            if (bus.overrun === 1'b1) ovPulses++;
            if (i == 195) begin
                nChecks++;
                if (bus.dataOutValid !== 1'b1 || bus.dataOut !== expVal(16'hFFFF) || bus.overrun !== 1'b0) begin
                    nFails++;
                    $display("FAIL ovr_first: got v=%b d=%h o=%b want v=1 d=%h o=0",
                             bus.dataOutValid, bus.dataOut, bus.overrun, expVal(16'hFFFF));
                end
            end
            if (i == 258) begin
                nChecks++;
                if (bus.dataOutValid !== 1'b1 || bus.dataOut !== expVal(16'hFFFF)) begin
                    nFails++;
                    $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=%h",
                             bus.dataOutValid, bus.dataOut, expVal(16'hFFFF));
                end
            end
            if (i == 259) begin
                nChecks++;
                if (bus.overrun !== 1'b1 || bus.dataOut !== expVal(16'hD750)) begin
                    nFails++;
                    $display("FAIL ovr_second: got o=%b d=%h want o=1 d=%h",
                             bus.overrun, bus.dataOut, expVal(16'hD750));
                end
            end
            if (i == 260) begin
                nChecks++;
                if (bus.overrun !== 1'b0) begin
                    nFails++;
                    $display("FAIL ovr_pulse_width: got %b want 0", bus.overrun);
                end
            end
            if (i == 261) begin
                nChecks++;
                if (bus.dataOutValid !== 1'b1) begin
                    nFails++;
                    $display("FAIL ovr_valid_held: got %b want 1", bus.dataOutValid);
                end
            end
            if (i == 262) begin
                nChecks++;
                if (bus.dataOutValid !== 1'b0) begin
                    nFails++;
                    $display("FAIL ovr_valid_clear: got %b want 0", bus.dataOutValid);
                end
            end
            if (i == 323) begin
                nChecks++;
                if (bus.dataOutValid !== 1'b1 || bus.dataOut !== expVal(16'h2CB0)) begin
                    nFails++;
                    $display("FAIL ovr_third: got v=%b d=%h want v=1 d=%h",
                             bus.dataOutValid, bus.dataOut, expVal(16'h2CB0));
                end
            end
            if (i == 387) begin
                nChecks++;
                if (bus.dataOutValid !== 1'b1 || bus.dataOut !== expVal(16'h0000)) begin
                    nFails++;
                    $display("FAIL ovr_fourth: got v=%b d=%h want v=1 d=%h",
                             bus.dataOutValid, bus.dataOut, expVal(16'h0000));
                end
            end
        end
        nChecks++;
        if (ovPulses != 1) begin
            nFails++;
            $display("FAIL ovr_count: got %0d want 1", ovPulses);
        end
    endtask

    task automatic test_mid_reset();
        int firstLoad = -1;
        doReset();
        bus.dataOutReady = 1'b0;
        for (int i = 0; i < 220; i++) begin
            step(1'b1, 1'b1);
        end
        nChecks++;
        if (bus.dataOutValid !== 1'b1) begin
            nFails++;
            $display("FAIL mid_pre_valid: got %b want 1", bus.dataOutValid);
        end
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        nChecks++;
        if (bus.dataOutValid !== 1'b0 || bus.overrun !== 1'b0 || bus.dataOut !== 16'h0000) begin
            nFails++;
            $display("FAIL mid_reset_state: got v=%b o=%b d=%h want v=0 o=0 d=0000",
                     bus.dataOutValid, bus.overrun, bus.dataOut);
        end
        bus.dataOutReady = 1'b1;
        for (int i = 0; i < 240; i++) begin
            step(1'b1, 1'b1);
            if (bus.dataOutValid === 1'b1 && firstLoad < 0) firstLoad = i;
        end
        nChecks++;
        if (firstLoad != 195) begin
            nFails++;
            $display("FAIL mid_latency: got %0d want 195", firstLoad);
        end
    endtask

    initial begin
        nChecks          = 0;
        nFails           = 0;
        reset            = 1'b1;
        bus.dataIn       = 1'b0;
        bus.dataInValid  = 1'b0;
        bus.dataOutReady = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_const_ones();
        test_const_zeros();
        test_alternating();
        test_half_valid();
        test_overrun();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/delta_sigma_decimator.md
# delta_sigma_decimator

Receive-side counterpart to the delta-sigma DAC modulator: converts a 1-bit delta-sigma bitstream into DATA_SIZE-bit PCM samples. Third-order CIC (sinc3) filter with decimation ratio R = 2^LOG2_DECIM, followed by saturation, scaling and a one-entry valid/ready output register. Used for modulator loopback checking and for external 1-bit ADC front-ends.

## Interface
- DATA_SIZE, 16, output sample width; must satisfy DATA_SIZE <= 3*LOG2_DECIM.
- LOG2_DECIM, 6, log2 of decimation ratio R; range 2..10.
- clk  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- dataIn  input  1  bitstream bit; 1 = +full-scale, 0 = zero.
- dataInValid  input  1  qualifies dataIn; bits are accepted only when high.
- dataOut  output  DATA_SIZE  decimated sample; reset 0.
- dataOutValid  output  1  sample available; reset 0.
- dataOutReady  input  1  consumer accepts the sample when high with dataOutValid.
- overrun  output  1  one-cycle pulse when an unconsumed sample is overwritten; reset 0.

## Operation
- Internal width W = 3*LOG2_DECIM + 1. Integrators and combs use modulo-2^W wraparound arithmetic; no saturation inside the CIC.
- Integrators: three cascaded W-bit registers, updated only on accepted bits: i1 += dataIn; i2 += i1; i3 += i2, each using the previous registered value.
- Decimation counter: LOG2_DECIM bits, increments per accepted bit, wraps. An accepted bit with counter == R-1 is a decimation event. i3 (post-update value) is captured into the comb pipeline.
- Combs: three registered stages, each y = x - x_prev, where x_prev is held from the previous event. Stage k updates one cycle after stage k-1.
- Raw result lies in [0, R^3]. Saturate R^3 to R^3-1, then dataOut = sat >> (3*LOG2_DECIM - DATA_SIZE).
- Settling: the first two events after reset produce no output. The first dataOutValid follows the third event.
- Output register: a new sample loads dataOut and sets dataOutValid. Valid clears on a cycle with dataOutValid && dataOutReady and no simultaneous load.
- If a new sample arrives while dataOutValid is high and dataOutReady is low, the new sample overwrites the old one and overrun pulses high for that cycle.
- If the load coincides with an accepting handshake, the old sample is consumed, the new sample loads, valid stays high, and no overrun occurs.
- Reset mid-operation: integrators, combs, counter, settling count and output register all clear. The next sample appears only after three full events.

## Timing
- Event accepted in cycle t: comb1 updates at t+1, comb2 at t+2, comb3 at t+3, dataOut/dataOutValid update at t+4. Fixed latency of 4 cycles.
- dataInValid may deassert at any time. Integrators and counter hold state; the comb pipeline continues to drain.
- Minimum event spacing is R >= 4 cycles, which exceeds the comb depth, so the pipeline never stalls.
- dataOut is stable while dataOutValid is high and no overwrite occurs.
- overrun is a registered output coincident with the overwriting load (cycle t+4).

## Configuration
- DELTA_SIGMA_DECIM_SIGNED_EN defined: dataOut is two's complement, with the MSB of the scaled value inverted (0x8000 -> 0x0000, 0xFFFF -> 0x7FFF, 0x0000 -> 0x8000 for DATA_SIZE=16).
- DELTA_SIGMA_DECIM_SIGNED_EN undefined: dataOut is unsigned offset-binary as described above.
- The macro does not change timing or handshake behaviour.

## Test plan
- Constant 1s, dataInValid=1, ready=1 (defaults) -> after settling every sample = 0xFFFF (raw 2^18 saturated); first valid 4 cycles after the 3rd event (cycle 3*64-1+4 after reset release).
- Constant 0s -> every sample 0x0000, exactly one valid pulse per 64 accepted bits.
- Alternating 1,0 pattern -> steady-state samples 0x8000; with DELTA_SIGMA_DECIM_SIGNED_EN -> 0x0000.
- dataInValid toggled 50% with constant 1s -> sample period 128 cycles, values unchanged (0xFFFF).
- ready held low across two events, input switched 1s->0s -> overrun pulses once at the second load, dataOut shows the newer value, and valid clears one cycle after ready rises.
- reset asserted for 1 cycle mid-period -> dataOutValid=0 and overrun=0 next cycle; no valid output until three full events later.
